reset_release_sequencer: RTL and testbench



---
 rtl/reset_release_sequencer_pkg.sv | 23 ++
 rtl/reset_release_sequencer_sync_2ff.sv | 25 ++
 rtl/reset_release_sequencer.sv | 161 ++++++++++++++++
 tb/tb_reset_release_sequencer.sv | 340 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/reset_release_sequencer_pkg.sv
// Shared definitions for the reset release sequencer: FSM state encoding,
// synchroniser depth and the sizing helper for the shared hold/wait counter.
package reset_release_sequencer_pkg;

  typedef enum logic [2:0] {
    ST_HOLD    = 3'd0,
    ST_RELEASE = 3'd1,
    ST_WAIT    = 3'd2,
    ST_RUN     = 3'd3,
    ST_FAULT   = 3'd4
  } seq_state_t;

  localparam int SYNC_STAGES = 2;

  // Counter must reach the larger of the two terminal values (span-1);
  // it saturates at all-ones, so it never wraps back into a match.
  function automatic int cnt_width(input int hold_cycles, input int timeout_cycles);
    int span;
    span = (hold_cycles > timeout_cycles) ? hold_cycles : timeout_cycles;
    return (span < 2) ? 1 : $clog2(span);
  endfunction

endpackage

// File: rtl/reset_release_sequencer_sync_2ff.sv
// Multi-bit flop-chain synchroniser (SYNC_STAGES deep, no reset) used to
// bring the asynchronous lock and done levels into the clk domain.
module reset_release_sequencer_sync_2ff
  import reset_release_sequencer_pkg::*;
#(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] sync_q [SYNC_STAGES];

  // Shift the asynchronous input through the synchroniser chain.
  always_ff @(posedge clk) begin
    sync_q[0] <= d;
    for (int i = 1; i < SYNC_STAGES; i++) begin
      sync_q[i] <= sync_q[i-1];
    end
  end

  assign q = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/reset_release_sequencer.sv
// Releases per-domain resets one at a time (index 0 first) once all clock
// locks have been stable for HOLD_CYCLES, waiting for each domain's done
// before releasing the next. Any lock loss (or a done drop once running)
// re-asserts every domain reset and restarts from HOLD.
// Optional macro RESET_SEQ_TIMEOUT_EN adds a per-domain done timeout that
// parks the sequencer in FAULT until reset.
module reset_release_sequencer
  import reset_release_sequencer_pkg::*;
#(
  parameter int NUM_DOMAINS    = 3,
  parameter int NUM_CLOCKS     = 3,
  parameter int HOLD_CYCLES    = 16,
  parameter int TIMEOUT_CYCLES = 1048576
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [NUM_CLOCKS-1:0]  clocks_ok,
  input  logic [NUM_DOMAINS-1:0] done,
  output logic [NUM_DOMAINS-1:0] domain_reset,
  output logic                   all_ready,
  output logic [((NUM_DOMAINS > 1) ? $clog2(NUM_DOMAINS) : 1)-1:0] stage,
  output logic                   fault,
  output seq_state_t             dbg_state
);

  localparam int STAGE_W = (NUM_DOMAINS > 1) ? $clog2(NUM_DOMAINS) : 1;
  localparam int CNT_W   = cnt_width(HOLD_CYCLES, TIMEOUT_CYCLES);

  localparam logic [CNT_W-1:0]   HOLD_LAST  = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0]   CNT_MAX    = '1;
  localparam logic [STAGE_W-1:0] STAGE_LAST = STAGE_W'(NUM_DOMAINS - 1);
`ifdef RESET_SEQ_TIMEOUT_EN
  localparam logic [CNT_W-1:0]   TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
`endif

  logic [NUM_CLOCKS-1:0]  clocks_ok_s;
  logic [NUM_DOMAINS-1:0] done_s;

  seq_state_t             state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d, cnt_inc;
  logic [STAGE_W-1:0]     stage_q, stage_d;
  logic [NUM_DOMAINS-1:0] dr_q, dr_d;
  logic                   ready_q, ready_d;

  logic lock_ok;
  logic done_cur;
  logic restart;

  reset_release_sequencer_sync_2ff #(.WIDTH(NUM_CLOCKS)) u_sync_clocks (
    .clk (clk),
    .d   (clocks_ok),
    .q   (clocks_ok_s)
  );

  reset_release_sequencer_sync_2ff #(.WIDTH(NUM_DOMAINS)) u_sync_done (
    .clk (clk),
    .d   (done),
    .q   (done_s)
  );

  assign lock_ok  = &clocks_ok_s;
  assign done_cur = done_s[stage_q];
  assign cnt_inc  = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;
  // A done dropping after all domains are up is handled exactly like a lock loss.
  assign restart  = !lock_ok || ((state_q == ST_RUN) && !(&done_s));

  // State, counter and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_HOLD;
      cnt_q   <= '0;
      stage_q <= '0;
      dr_q    <= '1;
      ready_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      stage_q <= stage_d;
      dr_q    <= dr_d;
      ready_q <= ready_d;
    end
  end

  // Next-state logic; restart wins over any simultaneous done, FAULT ignores it.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    stage_d = stage_q;
    dr_d    = dr_q;
    ready_d = 1'b0;
    if ((state_q != ST_FAULT) && restart) begin
      state_d = ST_HOLD;
      cnt_d   = '0;
      stage_d = '0;
      dr_d    = '1;
    end else begin
      case (state_q)
        ST_HOLD: begin
          if (cnt_q == HOLD_LAST) begin
            state_d = ST_RELEASE;
            stage_d = '0;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_inc;
          end
        end
        ST_RELEASE: begin
          dr_d[stage_q] = 1'b0;
          cnt_d         = '0;
          state_d       = ST_WAIT;
        end
        ST_WAIT: begin
          if (done_cur) begin
            cnt_d = '0;
            if (stage_q == STAGE_LAST) begin
              state_d = ST_RUN;
            end else begin
              stage_d = stage_q + 1'b1;
              state_d = ST_RELEASE;
            end
`ifdef RESET_SEQ_TIMEOUT_EN
          end else if (cnt_q == TIMEOUT_LAST) begin
            state_d = ST_FAULT;
            dr_d    = '1;
`endif
          end else begin
            cnt_d = cnt_inc;
          end
        end
        ST_RUN: begin
          ready_d = 1'b1;
        end
`ifdef RESET_SEQ_TIMEOUT_EN
        ST_FAULT: begin
          dr_d = '1;
        end
`endif
        default: begin
          state_d = ST_HOLD;
          cnt_d   = '0;
          stage_d = '0;
          dr_d    = '1;
        end
      endcase
    end
  end

  // Drive ports from the registered state.
  always_comb begin
    domain_reset = dr_q;
    all_ready    = ready_q;
    stage        = stage_q;
    dbg_state    = state_q;
`ifdef RESET_SEQ_TIMEOUT_EN
    fault        = (state_q == ST_FAULT);
`else
    fault        = 1'b0;
`endif
  end

endmodule

// File: tb/tb_reset_release_sequencer.sv
// Self-checking bench for reset_release_sequencer: expected domain reset
// release times are queued as stimulus is applied and checked when the
// falling edges appear; scenario tasks check levels inline.
`timescale 1ns/1ps
module tb_reset_release_sequencer;
  import reset_release_sequencer_pkg::*;

  localparam int ND   = 3;
  localparam int NC   = 3;
  localparam int HOLD = 16;
  localparam int TMO  = 64;
  localparam int EW   = 18;

  logic          clk;
  logic          reset;
  logic [NC-1:0] clocks_ok;
  logic [ND-1:0] done;
  logic [ND-1:0] domain_reset;
  logic          all_ready;
  logic [1:0]    stage;
  logic          fault;
  seq_state_t    dbg_state;

  int cyc      = 0;
  int n_checks = 0;
  int n_fail   = 0;

  // Each entry: {domain index, cycle at which its reset must fall}.
  logic [EW-1:0] exp_q[$];

  reset_release_sequencer #(
    .NUM_DOMAINS    (ND),
    .NUM_CLOCKS     (NC),
    .HOLD_CYCLES    (HOLD),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .clocks_ok    (clocks_ok),
    .done         (done),
    .domain_reset (domain_reset),
    .all_ready    (all_ready),
    .stage        (stage),
    .fault        (fault),
    .dbg_state    (dbg_state)
  );

  // Clock and cycle counter (cyc = number of rising edges so far).
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    forever begin
      @(posedge clk);
      cyc++;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  function automatic logic [EW-1:0] mk_exp(input int idx, input int c);
    return {idx[1:0], c[15:0]};
  endfunction

  task automatic push_fall(input int idx, input int at_cyc);
    exp_q.push_back(mk_exp(idx, at_cyc));
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  // Scoreboard: every falling domain reset must match the queue head.
  initial begin : monitor
    logic [ND-1:0] prev;
    logic [EW-1:0] e;
    logic [EW-1:0] got;
    prev = '1;
    forever begin
      @(negedge clk);
      for (int i = 0; i < ND; i++) begin
        if (prev[i] === 1'b1 && domain_reset[i] === 1'b0) begin
          n_checks++;
          got = mk_exp(i, cyc);
          if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL release_unexpected: domain %0d released at cycle %0d, none expected", i, cyc);
          end else begin
            e = exp_q.pop_front();
            if (got !== e) begin
              n_fail++;
              $display("FAIL release_time: got domain %0d cycle %0d, expected domain %0d cycle %0d",
                       i, cyc, e[17:16], e[15:0]);
            end
          end
        end
      end
      prev = domain_reset;
    end
  end

  task automatic test_reset;
    reset     = 1'b1;
    clocks_ok = '0;
    done      = '0;
    repeat (5) @(negedge clk);
    n_checks++;
    if (domain_reset !== 3'b111) begin n_fail++; $display("FAIL reset_dr: got %b expected 111", domain_reset); end
    n_checks++;
    if (all_ready !== 1'b0) begin n_fail++; $display("FAIL reset_ready: got %b expected 0", all_ready); end
    n_checks++;
    if (stage !== 2'd0) begin n_fail++; $display("FAIL reset_stage: got %0d expected 0", stage); end
    n_checks++;
    if (fault !== 1'b0) begin n_fail++; $display("FAIL reset_fault: got %b expected 0", fault); end
    n_checks++;
    if (dbg_state !== ST_HOLD) begin n_fail++; $display("FAIL reset_state: got %0d expected %0d", dbg_state, ST_HOLD); end
    reset = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++;
    if (domain_reset !== 3'b111) begin n_fail++; $display("FAIL nolock_dr: got %b expected 111", domain_reset); end
  endtask

  task automatic test_first_release;
    int p;
    p = cyc;
    clocks_ok = '1;
    push_fall(0, p + 19);
    wait_until(p + 18);
    n_checks++;
    if (domain_reset !== 3'b111) begin n_fail++; $display("FAIL first_early: got %b expected 111", domain_reset); end
    wait_until(p + 19);
    n_checks++;
    if (domain_reset !== 3'b110) begin n_fail++; $display("FAIL first_release: got %b expected 110", domain_reset); end
    n_checks++;
    if (stage !== 2'd0 || all_ready !== 1'b0) begin
      n_fail++; $display("FAIL first_stage: got stage %0d ready %b expected 0 0", stage, all_ready);
    end
  endtask

  task automatic test_sequence;
    int q;
    logic [ND-1:0] ones;
    logic [ND-1:0] exp_dr;
    logic [1:0]    exp_stage;
    ones = '1;
    for (int d = 0; d < ND; d++) begin
      repeat ($urandom_range(1, 4)) @(negedge clk);
      q = cyc;
      done[d] = 1'b1;
      if (d < ND - 1) begin
        push_fall(d + 1, q + 4);
        exp_stage = 2'(d + 1);
        wait_until(q + 3);
        n_checks++;
        if (stage !== exp_stage) begin n_fail++; $display("FAIL seq_stage: got %0d expected %0d", stage, exp_stage); end
        exp_dr = ones << (d + 2);
        wait_until(q + 4);
        n_checks++;
        if (domain_reset !== exp_dr) begin n_fail++; $display("FAIL seq_dr: got %b expected %b", domain_reset, exp_dr); end
      end else begin
        wait_until(q + 3);
        n_checks++;
        if (all_ready !== 1'b0 || dbg_state !== ST_RUN) begin
          n_fail++; $display("FAIL run_entry: got ready %b state %0d expected 0 %0d", all_ready, dbg_state, ST_RUN);
        end
        wait_until(q + 4);
        n_checks++;
        if (all_ready !== 1'b1) begin n_fail++; $display("FAIL run_ready: got %b expected 1", all_ready); end
        n_checks++;
        if (domain_reset !== 3'b000 || stage !== 2'd2) begin
          n_fail++; $display("FAIL run_outputs: got dr %b stage %0d expected 000 2", domain_reset, stage);
        end
      end
    end
  endtask

  task automatic test_lock_loss;
    int t;
    t = cyc;
    clocks_ok[1] = 1'b0;
    @(negedge clk);
    clocks_ok[1] = 1'b1;
    // All dones stay high, so the whole chain re-releases back to back.
    push_fall(0, t + 20);
    push_fall(1, t + 22);
    push_fall(2, t + 24);
    wait_until(t + 2);
    n_checks++;
    if (all_ready !== 1'b1) begin n_fail++; $display("FAIL loss_early: got ready %b expected 1", all_ready); end
    wait_until(t + 3);
    n_checks++;
    if (domain_reset !== 3'b111 || all_ready !== 1'b0 || stage !== 2'd0) begin
      n_fail++; $display("FAIL loss_reassert: got dr %b ready %b stage %0d expected 111 0 0", domain_reset, all_ready, stage);
    end
    wait_until(t + 19);
    n_checks++;
    if (domain_reset !== 3'b111) begin n_fail++; $display("FAIL loss_hold: got %b expected 111", domain_reset); end
    wait_until(t + 25);
    n_checks++;
    if (all_ready !== 1'b0) begin n_fail++; $display("FAIL loss_ready_early: got %b expected 0", all_ready); end
    wait_until(t + 26);
    n_checks++;
    if (all_ready !== 1'b1 || domain_reset !== 3'b000) begin
      n_fail++; $display("FAIL loss_rerun: got ready %b dr %b expected 1 000", all_ready, domain_reset);
    end
  endtask

  task automatic test_done_drop_hold_restart;
    int u;
    int b;
    u = cyc;
    done = '0;
    wait_until(u + 2);
    n_checks++;
    if (all_ready !== 1'b1) begin n_fail++; $display("FAIL drop_early: got ready %b expected 1", all_ready); end
    wait_until(u + 3);
    n_checks++;
    if (domain_reset !== 3'b111 || all_ready !== 1'b0 || dbg_state !== ST_HOLD) begin
      n_fail++; $display("FAIL drop_restart: got dr %b ready %b state %0d expected 111 0 %0d",
                         domain_reset, all_ready, dbg_state, ST_HOLD);
    end
    // Hold counter is at 10 here; a one-cycle lock glitch must restart it.
    wait_until(u + 13);
    b = $urandom_range(0, NC - 1);
    clocks_ok[b] = 1'b0;
    @(negedge clk);
    clocks_ok[b] = 1'b1;
    push_fall(0, u + 33);
    wait_until(u + 20);
    n_checks++;
    if (domain_reset !== 3'b111) begin n_fail++; $display("FAIL glitch_hold_20: got %b expected 111", domain_reset); end
    wait_until(u + 32);
    n_checks++;
    if (domain_reset !== 3'b111) begin n_fail++; $display("FAIL glitch_hold_32: got %b expected 111", domain_reset); end
    wait_until(u + 33);
    n_checks++;
    if (domain_reset !== 3'b110 || dbg_state !== ST_WAIT) begin
      n_fail++; $display("FAIL glitch_release: got dr %b state %0d expected 110 %0d", domain_reset, dbg_state, ST_WAIT);
    end
  endtask

  task automatic test_reset_in_wait;
    int v;
    int w;
    v = cyc;
    done[0] = 1'b1;
    push_fall(1, v + 4);
    wait_until(v + 4);
    n_checks++;
    if (stage !== 2'd1 || domain_reset !== 3'b100 || dbg_state !== ST_WAIT) begin
      n_fail++; $display("FAIL wait1: got stage %0d dr %b state %0d expected 1 100 %0d", stage, domain_reset, dbg_state, ST_WAIT);
    end
    repeat ($urandom_range(1, 3)) @(negedge clk);
    w = cyc;
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    n_checks++;
    if (domain_reset !== 3'b111 || stage !== 2'd0 || all_ready !== 1'b0 || fault !== 1'b0 || dbg_state !== ST_HOLD) begin
      n_fail++; $display("FAIL wait_reset: got dr %b stage %0d ready %b fault %b state %0d expected 111 0 0 0 %0d",
                         domain_reset, stage, all_ready, fault, dbg_state, ST_HOLD);
    end
    push_fall(0, w + 18);
    push_fall(1, w + 20);
    wait_until(w + 20);
    n_checks++;
    if (domain_reset !== 3'b100 || stage !== 2'd1) begin
      n_fail++; $display("FAIL post_reset: got dr %b stage %0d expected 100 1", domain_reset, stage);
    end
  endtask

  task automatic test_timeout;
    int x;
    reset = 1'b1;
    done  = '0;
    repeat (2) @(negedge clk);
    x = cyc;
    reset = 1'b0;
    push_fall(0, x + 17);
`ifdef RESET_SEQ_TIMEOUT_EN
    wait_until(x + 80);
    n_checks++;
    if (fault !== 1'b0 || domain_reset !== 3'b110) begin
      n_fail++; $display("FAIL tmo_early: got fault %b dr %b expected 0 110", fault, domain_reset);
    end
    wait_until(x + 81);
    n_checks++;
    if (fault !== 1'b1 || domain_reset !== 3'b111 || all_ready !== 1'b0 || dbg_state !== ST_FAULT) begin
      n_fail++; $display("FAIL tmo_fault: got fault %b dr %b ready %b state %0d expected 1 111 0 %0d",
                         fault, domain_reset, all_ready, dbg_state, ST_FAULT);
    end
    clocks_ok = '0;
    repeat (5) @(negedge clk);
    clocks_ok = '1;
    repeat (25) @(negedge clk);
    n_checks++;
    if (fault !== 1'b1 || domain_reset !== 3'b111) begin
      n_fail++; $display("FAIL tmo_sticky: got fault %b dr %b expected 1 111", fault, domain_reset);
    end
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    n_checks++;
    if (fault !== 1'b0 || dbg_state !== ST_HOLD || domain_reset !== 3'b111) begin
      n_fail++; $display("FAIL tmo_clear: got fault %b state %0d dr %b expected 0 %0d 111", fault, dbg_state, domain_reset, ST_HOLD);
    end
`else
    wait_until(x + 111);
    n_checks++;
    if (fault !== 1'b0 || domain_reset !== 3'b110 || dbg_state !== ST_WAIT || stage !== 2'd0) begin
      n_fail++; $display("FAIL no_timeout: got fault %b dr %b state %0d stage %0d expected 0 110 %0d 0",
                         fault, domain_reset, dbg_state, stage, ST_WAIT);
    end
`endif
  endtask

  initial begin
    test_reset();
    test_first_release();
    test_sequence();
    test_lock_loss();
    test_done_drop_hold_restart();
    test_reset_in_wait();
    test_timeout();
    repeat (2) @(negedge clk);
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++; $display("FAIL releases_missing: got %0d outstanding expected 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
